scroll_gen: RTL and testbench

//  Parametrised LED pattern scroller driving a WIDTH-bit LED bank with a lit block of BLOCK adjacent bits.

---
 rtl/scroll_gen_if.sv | 25 ++
 rtl/scroll_gen.sv | 124 ++++++++++++
 tb/tb_scroll_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/scroll_gen_if.sv
// Control and LED-side signals of the pattern scroller.
// The master drives the motion controls; the slave returns the registered pattern state.
interface scroll_gen_if #(
  parameter int WIDTH = 8
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             restart;
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] shift_out;
  logic [PW-1:0]    pos;
  logic             dir;
  logic             wrap_pulse;

  modport master (
    output restart, enable, mode,
    input  shift_out, pos, dir, wrap_pulse
  );

  modport slave (
    input  restart, enable, mode,
    output shift_out, pos, dir, wrap_pulse
  );
endinterface

// File: rtl/scroll_gen.sv
// LED block scroller: bounce / rotate-left / rotate-right / hold, stepped by a prescaler.
// Emits a one-cycle wrap_pulse at each end of travel.
//
// dir state | meaning
// DIR_DOWN  | bounce moving toward LSB (pos decrements)
// DIR_UP    | bounce moving toward MSB (pos increments)
module scroll_gen #(
  parameter int WIDTH    = 8,
  parameter int BLOCK    = 2,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  scroll_gen_if.slave bus
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROTL   = 2'b01;
  localparam logic [1:0] MODE_ROTR   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [0:0] DIR_DOWN = 1'b0;
  localparam logic [0:0] DIR_UP   = 1'b1;

  localparam logic [PW-1:0] POS_TOP    = PW'(WIDTH - BLOCK);
  localparam logic [PW-1:0] POS_TOP_M1 = PW'(WIDTH - BLOCK - 1);
  localparam logic [PW-1:0] POS_MAX    = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);

  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pos_q;
  logic [0:0]       dir_q;
  logic             wrap_q;
  logic [WIDTH-1:0] shift;
  int               off;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      pos_q  <= POS_TOP;
      dir_q  <= DIR_DOWN;
      wrap_q <= 1'b0;
    end else if (bus.restart) begin
      cnt    <= '0;
      pos_q  <= POS_TOP;
      dir_q  <= DIR_DOWN;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.enable && bus.mode != MODE_HOLD) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          case (bus.mode)
            MODE_BOUNCE: begin
              if (pos_q > POS_TOP) begin
                // arriving from a rotate mode outside the bounce range
                pos_q <= POS_TOP;
                dir_q <= DIR_DOWN;
              end else if (dir_q == DIR_DOWN) begin
                if (pos_q == '0) begin
                  pos_q <= POS_ONE;
                  dir_q <= DIR_UP;
                end else begin
                  pos_q <= pos_q - POS_ONE;
                  if (pos_q == POS_ONE) begin
                    dir_q  <= DIR_UP;
                    wrap_q <= 1'b1;
                  end
                end
              end else begin
                if (pos_q == POS_TOP) begin
                  pos_q <= pos_q - POS_ONE;
                  dir_q <= DIR_DOWN;
                end else begin
                  pos_q <= pos_q + POS_ONE;
                  if (pos_q == POS_TOP_M1) begin
                    dir_q  <= DIR_DOWN;
                    wrap_q <= 1'b1;
                  end
                end
              end
            end
            MODE_ROTL: begin
              if (pos_q == POS_MAX) begin
                pos_q  <= '0;
                wrap_q <= 1'b1;
              end else begin
                pos_q <= pos_q + POS_ONE;
              end
            end
            MODE_ROTR: begin
              if (pos_q == '0) begin
                pos_q  <= POS_MAX;
                wrap_q <= 1'b1;
              end else begin
                pos_q <= pos_q - POS_ONE;
              end
            end
            default: ;
          endcase
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    shift = '0;
    off   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      off = (i + WIDTH - int'(pos_q)) % WIDTH;
      if (off < BLOCK) shift[i] = 1'b1;
    end
  end

  assign bus.shift_out  = shift;
  assign bus.pos        = pos_q;
  assign bus.dir        = dir_q[0];
  assign bus.wrap_pulse = wrap_q;
endmodule

// File: tb/tb_scroll_gen.sv
// Directed bench for scroll_gen: vector table for motion modes plus
// hand sequences for async reset and the prescaler.
module tb_scroll_gen;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  scroll_gen_if #(.WIDTH(8)) bus  ();
  scroll_gen_if #(.WIDTH(8)) bus4 ();

  scroll_gen #(.WIDTH(8), .BLOCK(2), .PRESCALE(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  scroll_gen #(.WIDTH(8), .BLOCK(2), .PRESCALE(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    logic       restart;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] shift;
    logic [2:0] pos;
    logic       dir;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic r, logic e, logic [1:0] m,
                              logic [7:0] s, logic [2:0] p, logic d, logic w);
    vec_t v;
    v.restart = r; v.enable = e; v.mode = m;
    v.shift = s; v.pos = p; v.dir = d; v.wrap = w;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.restart  = 1'b0; bus.enable  = 1'b0; bus.mode  = 2'b00;
    bus4.restart = 1'b0; bus4.enable = 1'b0; bus4.mode = 2'b00;

    // bounce from reset, with a disabled cycle right after the LSB wrap
    add(0,1,0, 8'h60,5,0,0); add(0,1,0, 8'h30,4,0,0); add(0,1,0, 8'h18,3,0,0);
    add(0,1,0, 8'h0C,2,0,0); add(0,1,0, 8'h06,1,0,0); add(0,1,0, 8'h03,0,1,1);
    add(0,0,0, 8'h03,0,1,0); add(0,1,0, 8'h06,1,1,0); add(0,1,0, 8'h0C,2,1,0);
    add(0,1,0, 8'h18,3,1,0); add(0,1,0, 8'h30,4,1,0); add(0,1,0, 8'h60,5,1,0);
    add(0,1,0, 8'hC0,6,0,1); add(0,1,0, 8'h60,5,0,0);
    add(1,1,0, 8'hC0,6,0,0);
    // rotate-left from reset
    add(0,1,1, 8'h81,7,0,0); add(0,1,1, 8'h03,0,0,1); add(0,1,1, 8'h06,1,0,0);
    add(1,1,1, 8'hC0,6,0,0);
    // rotate-right from reset
    add(0,1,2, 8'h60,5,0,0); add(0,1,2, 8'h30,4,0,0); add(0,1,2, 8'h18,3,0,0);
    add(0,1,2, 8'h0C,2,0,0); add(0,1,2, 8'h06,1,0,0); add(0,1,2, 8'h03,0,0,0);
    add(0,1,2, 8'h81,7,0,1); add(0,1,2, 8'hC0,6,0,0);
    // hold
    add(0,1,3, 8'hC0,6,0,0); add(0,1,3, 8'hC0,6,0,0);
    // rotate to pos 7, then bounce clamps without a wrap
    add(0,1,1, 8'h81,7,0,0); add(0,1,0, 8'hC0,6,0,0); add(0,1,0, 8'h60,5,0,0);
    add(0,1,0, 8'h30,4,0,0); add(0,1,0, 8'h18,3,0,0); add(0,1,0, 8'h0C,2,0,0);
    add(0,1,0, 8'h06,1,0,0); add(0,1,0, 8'h03,0,1,1); add(0,1,0, 8'h06,1,1,0);
    add(0,1,0, 8'h0C,2,1,0); add(0,1,0, 8'h18,3,1,0);
    // rotate keeps dir; then restart coinciding with a step
    add(0,1,1, 8'h30,4,1,0); add(0,1,2, 8'h18,3,1,0);
    add(1,1,0, 8'hC0,6,0,0);

    #12;
    chk("rst_shift", 32'(bus.shift_out), 32'h0C0);
    chk("rst_pos",   32'(bus.pos), 32'd6);
    chk("rst_dir",   32'(bus.dir), 32'd0);
    chk("rst_wrap",  32'(bus.wrap_pulse), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle%0d_shift", i), 32'(bus.shift_out), 32'h0C0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      bus.restart = vecs[i].restart;
      bus.enable  = vecs[i].enable;
      bus.mode    = vecs[i].mode;
      tick();
      chk($sformatf("vec%0d_shift", i), 32'(bus.shift_out), 32'(vecs[i].shift));
      chk($sformatf("vec%0d_pos", i),   32'(bus.pos), 32'(vecs[i].pos));
      chk($sformatf("vec%0d_dir", i),   32'(bus.dir), 32'(vecs[i].dir));
      chk($sformatf("vec%0d_wrap", i),  32'(bus.wrap_pulse), 32'(vecs[i].wrap));
    end

    // async reset between edges while wrap_pulse is high
    bus.restart = 1'b0; bus.enable = 1'b1; bus.mode = 2'b00;
    repeat (6) tick();
    chk("pre_async_shift", 32'(bus.shift_out), 32'h003);
    chk("pre_async_wrap",  32'(bus.wrap_pulse), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("async_shift", 32'(bus.shift_out), 32'h0C0);
    chk("async_pos",   32'(bus.pos), 32'd6);
    chk("async_dir",   32'(bus.dir), 32'd0);
    chk("async_wrap",  32'(bus.wrap_pulse), 32'd0);
    bus.enable = 1'b0;
    #1 reset = 1'b1;

    // prescaler: one step per 4 enabled cycles, paused cycles don't count
    bus4.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ps_wait%0d", i), 32'(bus4.shift_out), 32'h0C0);
    end
    tick();
    chk("ps_step1_shift", 32'(bus4.shift_out), 32'h060);
    chk("ps_step1_pos",   32'(bus4.pos), 32'd5);
    repeat (2) tick();
    chk("ps_mid", 32'(bus4.shift_out), 32'h060);
    bus4.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ps_pause%0d", i), 32'(bus4.shift_out), 32'h060);
    end
    bus4.enable = 1'b1;
    tick();
    chk("ps_resume", 32'(bus4.shift_out), 32'h060);
    tick();
    chk("ps_step2_shift", 32'(bus4.shift_out), 32'h030);
    chk("ps_step2_pos",   32'(bus4.pos), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
